multicycle_main_fsm: RTL
========================

MULTICYCLE_MAIN_FSM -- requirements
Module: multicycle_main_fsm

Interface
REQ-001 Parameter: CNT_W, 32, width of retired-instruction counter.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: Op  input  2  instruction class from the instruction register: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Port: Funct  input  6  instruction funct field; Funct[5] = immediate, Funct[0] = load (1) / store (0).
REQ-006 Port: mem_ready  input  1  memory completes the current access this cycle.
REQ-007 Port: mem_req  output  1  memory access request.
REQ-008 Port: IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc  output  1 each  datapath strobes and selects.
REQ-009 Port: ALUSrcA  output  1; ALUSrcB, ResultSrc  output  2 each  datapath mux selects.
REQ-010 Port: illegal  output  1  one-cycle pulse on Op=11 decode.
REQ-011 Port: state  output  4  current state encoding.
REQ-012 Port: retired  output  CNT_W  retired-instruction count.

Function
REQ-013 States (encoding): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 unreachable and SHALL go to FETCH next cycle with all strobes 0.
REQ-014 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10; IRWrite=NextPC=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-015 DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10; next: Op=01 MEMADR; Op=00 and Funct[5]=0 EXECUTER; Op=00 and Funct[5]=1 EXECUTEI; Op=10 BRANCH; Op=11 FETCH with illegal=1 for this cycle.
REQ-016 MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0; next MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-017 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; stay while mem_ready=0, else go to MEMWB.
REQ-018 MEMWB: ResultSrc=01, RegW=1; next FETCH.
REQ-019 MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00, MemW=1 for every cycle in the state; stay while mem_ready=0, else go to FETCH.
REQ-020 EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUOp=1; next ALUWB.
REQ-021 EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUOp=1; next ALUWB.
REQ-022 ALUWB: ResultSrc=00, RegW=1; next FETCH.
REQ-023 BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1; next FETCH.
REQ-024 Any strobe or select not listed for a state SHALL be 0.
REQ-025 RegW, MemW and Branch are unconditioned requests; condition gating is done downstream.
REQ-026 All outputs except IRWrite and NextPC SHALL be decoded from state only; IRWrite and NextPC also depend on mem_ready.
REQ-027 retired SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH, and SHALL wrap from all-ones to 0.
REQ-028 retired SHALL NOT increment on an illegal decode.
REQ-029 Op and Funct are sampled only in DECODE and MEMADR; their values in other states SHALL have no effect.

Reset
REQ-030 While reset=1, the next state SHALL be FETCH and retired SHALL be 0.
REQ-031 Reset SHALL take priority over every transition, including a pending mem_ready, mid-wait in MEMREAD or MEMWRITE.
REQ-032 Because outputs are decoded from state, FETCH outputs appear in the cycle after reset is sampled.
REQ-033 No strobe other than FETCH's mem_req and mem_ready-gated IRWrite/NextPC SHALL be asserted in the first cycle after reset.

Verification
REQ-034 ADD reg, Op=00, Funct[5]=0, mem_ready=1 -> states 0,1,6,8,0; RegW=1 only in state 8; retired 0->1.
REQ-035 LDR, Op=01, Funct[0]=1, mem_ready low 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; RegW=1 in state 4 with ResultSrc=01.
REQ-036 STR, Op=01, Funct[0]=0, mem_ready low 3 cycles -> MemW=1 and mem_req=1 for 4 cycles in state 5; IRWrite never 1 there.
REQ-037 FETCH with mem_ready=0 for 5 cycles -> state stays 0; IRWrite=NextPC=0 for those cycles, then a single pulse of 1 with mem_ready.
REQ-038 Branch, Op=10 -> states 0,1,9,0 with Branch=1 in state 9; Op=11 -> illegal pulse in DECODE, retired unchanged.
REQ-039 reset=1 asserted in MEMREAD while mem_ready=1 -> next state 0 and retired=0; retired=all-ones plus one ALUWB -> retired=0.

Source files
------------

// File: rtl/multicycle_main_fsm.sv
// Main control FSM for a multicycle processor.
// Sequences fetch, decode, memory access, execute and writeback for
// data-processing, memory and branch instructions. It also counts retired
// instructions and flags undefined opcodes.
module multicycle_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             RegW,
    output logic             MemW,
    output logic             Branch,
    output logic             ALUOp,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] BRANCH   = 4'd9;

    logic [3:0] nextState;
    logic       retire;

    // Choose the next state; Op/Funct only matter in DECODE and MEMADR, and undefined codes fall back to FETCH.
    always_comb begin
        nextState = FETCH;
        case (state)
            FETCH:    nextState = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b00:   nextState = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   nextState = MEMADR;
                    2'b10:   nextState = BRANCH;
                    default: nextState = FETCH;
                endcase
            end
            MEMADR:   nextState = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  nextState = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    nextState = FETCH;
            MEMWRITE: nextState = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: nextState = ALUWB;
            EXECUTEI: nextState = ALUWB;
            ALUWB:    nextState = FETCH;
            BRANCH:   nextState = FETCH;
            default:  nextState = FETCH;
        endcase
    end

    // An instruction retires when its final state hands control back to FETCH; illegal decodes never retire.
    always_comb begin
        retire = 1'b0;
        case (state)
            MEMWB:    retire = 1'b1;
            MEMWRITE: retire = mem_ready;
            ALUWB:    retire = 1'b1;
            BRANCH:   retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    // State register; reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // Retired-instruction counter; wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // Decode the datapath controls from state; only IRWrite/NextPC also look at mem_ready, and illegal at Op.
    always_comb begin
        mem_req   = 1'b0;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        illegal   = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                NextPC    = mem_ready;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                illegal   = (Op == 2'b11);
            end
            MEMADR: begin
                ALUSrcB   = 2'b01;
            end
            MEMREAD: begin
                mem_req   = 1'b1;
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
            end
            EXECUTER: begin
                ALUOp     = 1'b1;
            end
            EXECUTEI: begin
                ALUSrcB   = 2'b01;
                ALUOp     = 1'b1;
            end
            ALUWB: begin
                RegW      = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: begin
                mem_req   = 1'b0;
            end
        endcase
    end

endmodule
